// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } pc_state_e;

  localparam logic [63:0] PC_INC           = 64'd4;
  localparam logic [63:0] RESET_VECTOR_DEF = 64'h0;
  localparam logic [63:0] TRAP_VECTOR_DEF  = 64'h100;
  localparam int          INST_W_DEF       = 32;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: misaligned redirect > redirect > +4 after a fetch > hold.
module next_pc_sel
  import pc_seq_pkg::*;
#(
  parameter logic [63:0] TRAP_VECTOR = TRAP_VECTOR_DEF
) (
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_target,
  input  logic        i_pc_inc,
  input  logic [63:0] i_pc,
  output logic [63:0] o_next_pc,
  output logic        o_misalign
);

  always_comb begin
    o_misalign = i_redirect && (i_redirect_target[1:0] != 2'b00);
    o_next_pc  = i_pc;
    if (o_misalign) begin
      o_next_pc = TRAP_VECTOR;
    end else if (i_redirect) begin
      o_next_pc = i_redirect_target;
    end else if (i_pc_inc) begin
      o_next_pc = i_pc + PC_INC;  // wraps modulo 2^64
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction fetch sequencer: one outstanding imem fetch,
// redirect/trap handling and a 1-entry valid/ready buffer towards decode.
//
// state | meaning
// IDLE  | out of reset, waiting for stall to drop
// REQ   | fetch request may be presented at pc_out
// WAIT  | request accepted, waiting for the imem response
// HOLD  | output buffer full and not consumed; no request issued
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [63:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter int          INST_W       = INST_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_imem_req_valid,
  input  logic              i_imem_req_ready,
  output logic [63:0]       o_imem_req_addr,
  input  logic              i_imem_resp_valid,
  input  logic [INST_W-1:0] i_imem_resp_inst,
  input  logic              i_redirect,
  input  logic [63:0]       i_redirect_target,
  input  logic              i_stall,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst_data,
  output logic [63:0]       o_inst_pc,
  output logic              o_misalign_err,
  output logic [63:0]       o_pc_out
);

  pc_state_e         r_state;
  logic [63:0]       r_pc;
  logic              r_kill;
  logic              r_req_pend;
  logic              r_inst_valid;
  logic [INST_W-1:0] r_inst_data;
  logic [63:0]       r_inst_pc;
  logic              r_misalign;

  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_load;
  logic [63:0]       w_next_pc;
  logic              w_misalign;

  // A new request is only started when the buffer will be free by the time the
  // response lands; once presented it stays up until accepted.
  assign w_req_valid = (r_state == ST_REQ) &&
                       (r_req_pend || (!i_stall && (!r_inst_valid || i_inst_ready)));
  assign w_req_fire  = w_req_valid && i_imem_req_ready;
  assign w_load      = (r_state == ST_WAIT) && i_imem_resp_valid && !r_kill && !i_redirect;

  next_pc_sel #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_next_pc_sel (
    .i_redirect       (i_redirect),
    .i_redirect_target(i_redirect_target),
    .i_pc_inc         (w_load),
    .i_pc             (r_pc),
    .o_next_pc        (w_next_pc),
    .o_misalign       (w_misalign)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_VECTOR;
      r_kill       <= 1'b0;
      r_req_pend   <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
      r_inst_pc    <= '0;
      r_misalign   <= 1'b0;
    end else begin
      r_pc       <= w_next_pc;
      r_misalign <= w_misalign;
      r_req_pend <= w_req_valid && !i_imem_req_ready;

      if (i_redirect) begin
        r_inst_valid <= 1'b0;
      end else if (w_load) begin
        r_inst_valid <= 1'b1;
        r_inst_data  <= i_imem_resp_inst;
        r_inst_pc    <= r_pc;
      end else if (r_inst_valid && i_inst_ready) begin
        r_inst_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (!i_stall) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (w_req_fire) begin
            r_state <= ST_WAIT;
            r_kill  <= i_redirect;
          end else if (!w_req_valid && r_inst_valid && !i_inst_ready && !i_redirect) begin
            r_state <= ST_HOLD;
          end
        end
        ST_WAIT: begin
          // A response coinciding with a redirect is dropped directly, so no kill is left behind.
          if (i_imem_resp_valid) begin
            r_state <= ST_REQ;
            r_kill  <= 1'b0;
          end else if (i_redirect) begin
            r_kill <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (i_redirect || !r_inst_valid || i_inst_ready) r_state <= ST_REQ;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_pc;
  assign o_inst_valid     = r_inst_valid;
  assign o_inst_data      = r_inst_data;
  assign o_inst_pc        = r_inst_pc;
  assign o_misalign_err   = r_misalign;
  assign o_pc_out         = r_pc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a small imem responder model.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [63:0] o_imem_req_addr;
  logic        i_imem_resp_valid;
  logic [31:0] i_imem_resp_inst;
  logic        i_redirect;
  logic [63:0] i_redirect_target;
  logic        i_stall;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst_data;
  logic [63:0] o_inst_pc;
  logic        o_misalign_err;
  logic [63:0] o_pc_out;

  pc_fetch_sequencer dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_resp_valid(i_imem_resp_valid),
    .i_imem_resp_inst (i_imem_resp_inst),
    .i_redirect       (i_redirect),
    .i_redirect_target(i_redirect_target),
    .i_stall          (i_stall),
    .o_inst_valid     (o_inst_valid),
    .i_inst_ready     (i_inst_ready),
    .o_inst_data      (o_inst_data),
    .o_inst_pc        (o_inst_pc),
    .o_misalign_err   (o_misalign_err),
    .o_pc_out         (o_pc_out)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          lat = 1;
  int          pend_cnt = 0;
  int          mis_cnt = 0;
  logic [63:0] pend_addr = '0;
  logic [63:0] req_q[$];
  logic [63:0] opc_q[$];
  logic [31:0] odat_q[$];

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {16'h0013, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then drive imem response after it.
  task automatic cyc();
    logic        hs;
    logic        cons;
    logic [63:0] a;
    logic [63:0] cpc;
    logic [31:0] cdat;
    #1;
    hs   = (o_imem_req_valid && i_imem_req_ready) === 1'b1;
    a    = o_imem_req_addr;
    cons = (o_inst_valid && i_inst_ready) === 1'b1;
    cpc  = o_inst_pc;
    cdat = o_inst_data;
    @(posedge clk);
    if (hs) req_q.push_back(a);
    if (cons) begin
      opc_q.push_back(cpc);
      odat_q.push_back(cdat);
    end
    @(negedge clk);
    if (o_misalign_err === 1'b1) mis_cnt++;
    i_imem_resp_valid = 1'b0;
    if (pend_cnt != 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        i_imem_resp_valid = 1'b1;
        i_imem_resp_inst  = inst_of(pend_addr);
      end
    end
    if (hs) begin
      pend_addr = a;
      pend_cnt  = lat - 1;
      if (lat == 1) begin
        i_imem_resp_valid = 1'b1;
        i_imem_resp_inst  = inst_of(a);
      end
    end
    #1;
  endtask

  task automatic clear_model();
    pend_cnt = 0;
    i_imem_resp_valid = 1'b0;
    mis_cnt = 0;
    req_q.delete();
    opc_q.delete();
    odat_q.delete();
  endtask

  task automatic do_reset(input int n);
    i_reset      = 1'b0;
    i_redirect   = 1'b0;
    i_inst_ready = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    i_reset = 1'b1;
    clear_model();
  endtask

  task automatic run_until_out(input int n, input string tag);
    for (int i = 0; i < 60 && opc_q.size() < n; i++) cyc();
    chk({tag, "_out_cnt"}, 64'(opc_q.size()), 64'(n));
  endtask

  task automatic run_until_req(input int n, input string tag);
    for (int i = 0; i < 60 && req_q.size() < n; i++) cyc();
    chk({tag, "_req_cnt"}, 64'(req_q.size()), 64'(n));
  endtask

  logic [63:0] exp_pc[4]  = '{64'h0, 64'h4, 64'h8, 64'hC};
  logic [31:0] exp_dat[4] = '{32'h0013_0000, 32'h0013_0004, 32'h0013_0008, 32'h0013_000C};

  initial begin
    i_reset = 1'b0; i_imem_req_ready = 1'b1; i_imem_resp_valid = 1'b0; i_imem_resp_inst = '0;
    i_redirect = 1'b0; i_redirect_target = '0; i_stall = 1'b0; i_inst_ready = 1'b1;
    @(negedge clk);

    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_inst_valid", 64'(o_inst_valid), 64'h0);
    end
    chk("rst_pc", o_pc_out, 64'h0);
    i_reset = 1'b1;
    clear_model();
    cyc();
    chk("first_req_valid", 64'(o_imem_req_valid), 64'h1);
    chk("first_req_addr", o_imem_req_addr, 64'h0);

    // four sequential fetches, 1-cycle imem
    run_until_out(4, "seq");
    for (int k = 0; k < 4; k++) begin
      chk("seq_pc", opc_q[k], exp_pc[k]);
      chk("seq_data", 64'(odat_q[k]), 64'(exp_dat[k]));
    end
    chk("seq_pc_out", o_pc_out, 64'h10);

    // redirect while waiting on the fetch of 0x8
    do_reset(2);
    lat = 2;
    run_until_req(3, "redir");
    chk("redir_req8", req_q[2], 64'h8);
    i_redirect = 1'b1; i_redirect_target = 64'h2000;
    cyc();
    i_redirect = 1'b0;
    chk("redir_pc", o_pc_out, 64'h2000);
    run_until_req(4, "redir2");
    chk("redir_next_addr", req_q[3], 64'h2000);
    run_until_out(3, "redir3");
    chk("redir_out_pc", opc_q[2], 64'h2000);
    chk("redir_out_data", 64'(odat_q[2]), 64'h0013_2000);

    // misaligned redirect coinciding with a request handshake
    do_reset(2);
    lat = 1;
    cyc();
    i_redirect = 1'b1; i_redirect_target = 64'h2002;
    cyc();
    i_redirect = 1'b0;
    chk("mis_pulse", 64'(o_misalign_err), 64'h1);
    chk("mis_pc", o_pc_out, 64'h100);
    cyc();
    chk("mis_pulse_end", 64'(o_misalign_err), 64'h0);
    run_until_out(1, "mis");
    chk("mis_out_pc", opc_q[0], 64'h100);
    chk("mis_req_addr", req_q[1], 64'h100);
    chk("mis_cnt", 64'(mis_cnt), 64'h1);

    // back-pressure from decode
    do_reset(2);
    i_inst_ready = 1'b0;
    for (int i = 0; i < 20 && o_inst_valid !== 1'b1; i++) cyc();
    chk("bp_valid", 64'(o_inst_valid), 64'h1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_data", 64'(o_inst_data), 64'h0013_0000);
      chk("bp_pc", o_inst_pc, 64'h0);
    end
    chk("bp_no_req", 64'(req_q.size()), 64'h1);
    chk("bp_req_valid", 64'(o_imem_req_valid), 64'h0);
    i_inst_ready = 1'b1;
    run_until_out(2, "bp");
    chk("bp_next_pc", opc_q[1], 64'h4);

    // stall gating, PC wrap, then reset during WAIT
    i_stall = 1'b1;
    do_reset(2);
    cyc();
    cyc();
    chk("stall_req_valid", 64'(o_imem_req_valid), 64'h0);
    chk("stall_no_req", 64'(req_q.size()), 64'h0);
    i_redirect = 1'b1; i_redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    i_redirect = 1'b0;
    chk("wrap_pc_set", o_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    i_stall = 1'b0;
    run_until_out(1, "wrap");
    chk("wrap_out_pc", opc_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_out_data", 64'(odat_q[0]), 64'h0013_FFFC);
    chk("wrap_pc_out", o_pc_out, 64'h0);
    chk("wrap_req_addr", req_q[1], 64'h0);
    lat = 2;
    run_until_req(3, "rstw");
    chk("rstw_req4", req_q[2], 64'h4);
    i_reset = 1'b0;
    cyc();
    chk("rstw_pc", o_pc_out, 64'h0);
    chk("rstw_inst_valid", 64'(o_inst_valid), 64'h0);
    chk("rstw_req_valid", 64'(o_imem_req_valid), 64'h0);
    i_reset = 1'b1;
    req_q.delete();
    opc_q.delete();
    odat_q.delete();
    run_until_out(1, "rstw2");
    chk("rstw_out_pc", opc_q[0], 64'h0);
    chk("rstw_out_data", 64'(odat_q[0]), 64'h0013_0000);
    chk("rstw_req_addr", req_q[0], 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
